// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even parity is the XOR of all data bits,
// odd parity is its inverse.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  logic even_par;

  assign even_par = ^data_i;

  // Select even or odd parity from the requested type.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    parity_o = even_par;
    case (par_typ_i)
      PAR_EVEN: parity_o = even_par;
      PAR_ODD:  parity_o = ~even_par;
      default:  parity_o = even_par;
    endcase
  end

endmodule : uart_parity_calc

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops words from the FIFO read port and sends each as
// start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
// One frame bit per CLK cycle; back-to-back frames have no idle gap.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  FIFO_EMPTY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  RD_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  load_parity;

  // Parity is computed from the head word at load time, so the parity type
  // only matters on the load edge and is captured in par_bit_q.
  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i    (P_DATA),
    .par_typ_i (PAR_TYP),
    .parity_o  (load_parity)
  );

  // A word is accepted whenever the line is free or finishing its stop bit.
  assign RD_INC = ((state_q == IDLE) || (state_q == STOP)) && !FIFO_EMPTY;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      IDLE: begin
        if (RD_INC) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = load_parity;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        if (RD_INC) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = load_parity;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // TX_OUT is registered, so it is driven from the state being entered.
    case (state_d)
      START:   tx_out_d = START_BIT;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = par_bit_d;
      STOP:    tx_out_d = STOP_BIT;
      default: tx_out_d = IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset returns the line to idle at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_out_q;
  assign BUSY   = busy_q;

endmodule : uart_tx_serializer
